uart_tx_buffer: RTL and testbench



---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_buffer_if.sv | 16 +
 rtl/uart_fifo_mem.sv | 60 ++++++
 rtl/uart_tx_buffer.sv | 133 +++++++++++++
 tb/tb_uart_tx_buffer.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and types.
//   BYTE_W               - data byte width
//   DEFAULT_DEPTH        - default buffer depth (shared with the rx side)
//   DEFAULT_BUSY_TIMEOUT - default cycles to wait for tx_busy to rise
//   tx_state_e           - transmit launch FSM encoding
package uart_pkg;

    localparam int unsigned BYTE_W               = 8;
    localparam int unsigned DEFAULT_DEPTH        = 16;
    localparam int unsigned DEFAULT_BUSY_TIMEOUT = 15;
    localparam int unsigned TMO_W                = 8;

    typedef logic [BYTE_W-1:0] byte_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_BUSY = 2'd2,
        ST_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Host write channel into the transmit buffer.
//   wr_data  - host byte
//   wr_valid - host byte valid
//   wr_ready - buffer can accept a byte
// master = host side, slave = buffer side.
interface uart_tx_buffer_if;
    import uart_pkg::*;

    byte_t wr_data;
    logic  wr_valid;
    logic  wr_ready;

    modport master (output wr_data, output wr_valid, input wr_ready);
    modport slave  (input wr_data, input wr_valid, output wr_ready);

endinterface

// File: rtl/uart_fifo_mem.sv
// Synchronous byte FIFO with occupancy and flush.
//   clk, reset - clock, synchronous active-high reset
//   push_i     - write wdata_i at the tail
//   pop_i      - advance the head (rdata_o shows the head)
//   flush_i    - drop all entries; pointers equal next cycle
//   count_o    - occupancy 0..DEPTH
//   full_o     - count_o == DEPTH
//   empty_o    - count_o == 0
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH = DEFAULT_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic        flush_i,
    input  byte_t       wdata_i,
    output byte_t       rdata_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    byte_t       mem_q [DEPTH];
    logic [AW:0] wptr_q;
    logic [AW:0] rptr_q;

    // Extra pointer bit distinguishes full from empty; wrap is modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (push_i) begin
                wptr_q <= wptr_q + (AW+1)'(1);
            end
            if (flush_i) begin
                rptr_q <= wptr_q;
            end else if (pop_i) begin
                rptr_q <= rptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage array, no reset needed.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rptr_q[AW-1:0]];
    assign count_o = wptr_q - rptr_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (count_o == '0);

endmodule

// File: rtl/uart_tx_buffer.sv
// Byte buffer and launch controller in front of the UART transmitter.
//   clk, reset    - clock, synchronous active-high reset
//   wr_if         - host valid/ready byte channel (slave)
//   flush_i       - discard queued bytes (in-flight byte unaffected)
//   clr_status_i  - clear sticky flags (a same-cycle set wins)
//   tx_data_o     - byte presented to the transmitter
//   tx_start_o    - one-cycle launch pulse
//   tx_busy_i     - transmitter busy for the duration of a frame
//   count_o       - FIFO occupancy 0..DEPTH
//   overflow_o    - sticky: wr_valid seen while full
//   timeout_err_o - sticky: tx_busy never rose after tx_start
module uart_tx_buffer
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH        = DEFAULT_DEPTH,
    parameter  int unsigned BUSY_TIMEOUT = DEFAULT_BUSY_TIMEOUT,
    localparam int unsigned AW           = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_buffer_if.slave   wr_if,
    input  logic              flush_i,
    input  logic              clr_status_i,
    output byte_t             tx_data_o,
    output logic              tx_start_o,
    input  logic              tx_busy_i,
    output logic [AW:0]       count_o,
    output logic              overflow_o,
    output logic              timeout_err_o
);

    tx_state_e        state_q, state_d;
    byte_t            tx_data_q, tx_data_d;
    logic             tx_start_q;
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             overflow_q, overflow_d;
    logic             timeout_err_q, timeout_err_d;

    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             tmo_hit;
    byte_t            fifo_rdata;

    // No bypass: a full buffer refuses writes even when popping this cycle.
    assign wr_if.wr_ready = !full && !flush_i && !reset;
    assign push           = wr_if.wr_valid && wr_if.wr_ready;

    uart_fifo_mem #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (wr_if.wr_data),
        .rdata_o (fifo_rdata),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            tx_data_q     <= '0;
            tx_start_q    <= 1'b0;
            tmo_cnt_q     <= '0;
            overflow_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            tx_data_q     <= tx_data_d;
            tx_start_q    <= (state_d == ST_START);
            tmo_cnt_q     <= tmo_cnt_d;
            overflow_q    <= overflow_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Launch FSM, timeout counter and sticky flags.
    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        tmo_cnt_d = tmo_cnt_q;
        pop       = 1'b0;
        tmo_hit   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    tx_data_d = fifo_rdata;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                tmo_cnt_d = '0;
                state_d   = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy_i) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
                    // Byte is abandoned on timeout, not retried.
                    if (tmo_cnt_d == TMO_W'(BUSY_TIMEOUT)) begin
                        tmo_hit = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        overflow_d    = (overflow_q && !clr_status_i) || (wr_if.wr_valid && full);
        timeout_err_d = (timeout_err_q && !clr_status_i) || tmo_hit;
    end

    assign tx_data_o     = tx_data_q;
    assign tx_start_o    = tx_start_q;
    assign overflow_o    = overflow_q;
    assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Directed self-checking bench for uart_tx_buffer with a byte scoreboard.
module tb_uart_tx_buffer;

    localparam int unsigned DEPTH        = 16;
    localparam int unsigned BUSY_TIMEOUT = 15;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       clr_status;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_busy;
    logic [4:0] count;
    logic       overflow;
    logic       timeout_err;

    uart_tx_buffer_if bus ();

    uart_tx_buffer #(
        .DEPTH        (DEPTH),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_if         (bus),
        .flush_i       (flush),
        .clr_status_i  (clr_status),
        .tx_data_o     (tx_data),
        .tx_start_o    (tx_start),
        .tx_busy_i     (tx_busy),
        .count_o       (count),
        .overflow_o    (overflow),
        .timeout_err_o (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    int         cycle = 0;
    int         starts = 0;
    int         last_start_cyc = -1;
    int         fall_cyc = -1;
    int         max_count = 0;
    int         busy_left = 0;
    int         rise_wait = 0;
    int         rise_delay = 1;
    int         busy_len = 1;
    bit         model_on = 1'b0;
    bit         gap_on = 1'b0;
    int         last_wr_cyc = 0;
    logic [7:0] exp_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs 1 time unit after the edge, score launches, run transmitter model.
    task automatic cyc();
        logic [7:0] e;
        @(posedge clk);
        #1;
        cycle++;
        if (int'(count) > max_count) max_count = int'(count);
        if (tx_start === 1'b1) begin
            starts++;
            last_start_cyc = cycle;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("tx_data", 32'(tx_data), 32'(e));
            end else begin
                chk("unexpected_start", 32'(tx_start), 32'(0));
            end
            if (gap_on && fall_cyc >= 0) chk("b2b_gap", 32'(cycle - fall_cyc), 32'(2));
        end
        if (model_on) begin
            if (busy_left > 0) begin
                busy_left--;
                if (busy_left == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cycle;
                end
            end
            if (rise_wait > 0) begin
                rise_wait--;
                if (rise_wait == 0) begin
                    tx_busy   = 1'b1;
                    busy_left = busy_len;
                end
            end
            if (tx_start === 1'b1) rise_wait = rise_delay;
        end
    endtask

    // Offer one byte until accepted; accepted bytes go to the scoreboard.
    task automatic wr(input logic [7:0] b);
        int   n;
        logic acc;
        n   = 0;
        acc = 1'b0;
        bus.wr_data  = b;
        bus.wr_valid = 1'b1;
        while (!acc && n < 500) begin
            #1;
            if (bus.wr_ready === 1'b1) begin
                acc         = 1'b1;
                last_wr_cyc = cycle;
                exp_q.push_back(b);
            end
            cyc();
            n++;
        end
        if (!acc) chk("wr_accept_timeout", 32'(bus.wr_ready), 32'(1));
        bus.wr_valid = 1'b0;
    endtask

    // Run until nothing is queued or in flight.
    task automatic drain(input int bound);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || rise_wait != 0 || count != 0) && n < bound) begin
            cyc();
            n++;
        end
        chk("drain_count", 32'(count), 32'(0));
        chk("drain_sb_empty", 32'(exp_q.size()), 32'(0));
        repeat (3) cyc();
    endtask

    initial begin
        int n0;
        int s;

        reset        = 1'b1;
        flush        = 1'b0;
        clr_status   = 1'b0;
        tx_busy      = 1'b0;
        bus.wr_data  = 8'h00;
        bus.wr_valid = 1'b0;

        // Reset values
        repeat (2) cyc();
        chk("rst_count", 32'(count), 32'(0));
        chk("rst_tx_data", 32'(tx_data), 32'(0));
        chk("rst_tx_start", 32'(tx_start), 32'(0));
        chk("rst_overflow", 32'(overflow), 32'(0));
        chk("rst_timeout", 32'(timeout_err), 32'(0));
        chk("rst_wr_ready", 32'(bus.wr_ready), 32'(0));
        reset = 1'b0;
        cyc();
        chk("ready_after_rst", 32'(bus.wr_ready), 32'(1));

        // Single byte: launch at write cycle + 2, one-cycle pulse
        model_on = 1'b1; rise_delay = 1; busy_len = 10;
        n0 = starts;
        wr(8'hA5);
        chk("single_count_n1", 32'(count), 32'(1));
        chk("single_nostart_n1", 32'(tx_start), 32'(0));
        cyc();
        chk("single_start_cyc", 32'(last_start_cyc), 32'(last_wr_cyc + 2));
        cyc();
        chk("single_pulse_len", 32'(tx_start), 32'(0));
        chk("single_data_hold", 32'(tx_data), 32'(8'hA5));
        repeat (12) cyc();
        chk("single_count_end", 32'(count), 32'(0));
        chk("single_starts", 32'(starts - n0), 32'(1));
        chk("single_overflow", 32'(overflow), 32'(0));
        chk("single_timeout", 32'(timeout_err), 32'(0));

        // Fill and overflow with transmitter stuck busy
        model_on = 1'b0;
        tx_busy  = 1'b1;
        n0 = starts;
        for (int i = 0; i < 17; i++) wr(8'(i));
        chk("fill_count16", 32'(count), 32'(16));
        chk("fill_overflow_pre", 32'(overflow), 32'(0));
        bus.wr_data  = 8'h11;
        bus.wr_valid = 1'b1;
        #1;
        chk("full_wr_ready", 32'(bus.wr_ready), 32'(0));
        cyc();
        chk("overflow_set", 32'(overflow), 32'(1));
        clr_status = 1'b1;
        cyc();
        chk("overflow_set_wins", 32'(overflow), 32'(1));
        bus.wr_valid = 1'b0;
        cyc();
        clr_status = 1'b0;
        chk("overflow_cleared", 32'(overflow), 32'(0));
        chk("fill_count_hold", 32'(count), 32'(16));
        tx_busy = 1'b0; busy_left = 0; rise_wait = 0;
        model_on = 1'b1; rise_delay = 1; busy_len = 3;
        drain(2000);
        chk("fill_starts", 32'(starts - n0), 32'(17));

        // Ordered stream with wrap-around
        rise_delay = 2; busy_len = 5;
        fall_cyc = -1; max_count = 0; gap_on = 1'b1;
        n0 = starts;
        for (int i = 0; i < 40; i++) wr(8'(i));
        drain(3000);
        gap_on = 1'b0;
        chk("stream_starts", 32'(starts - n0), 32'(40));
        chk("stream_max_count", 32'(max_count), 32'(16));

        // Busy-rise timeout, next byte launches normally
        model_on = 1'b0;
        tx_busy  = 1'b0;
        wr(8'h3C);
        n0 = last_wr_cyc;
        wr(8'h4D);
        s = last_start_cyc;
        chk("tmo_first_start", 32'(s), 32'(n0 + 2));
        while (cycle < s + 15) cyc();
        chk("tmo_not_yet", 32'(timeout_err), 32'(0));
        cyc();
        chk("tmo_set", 32'(timeout_err), 32'(1));
        cyc();
        chk("tmo_next_start", 32'(last_start_cyc), 32'(s + 17));
        tx_busy = 1'b1;
        repeat (3) cyc();
        tx_busy = 1'b0;
        repeat (3) cyc();
        chk("tmo_sticky", 32'(timeout_err), 32'(1));
        clr_status = 1'b1;
        cyc();
        clr_status = 1'b0;
        chk("tmo_cleared", 32'(timeout_err), 32'(0));
        chk("tmo_count", 32'(count), 32'(0));

        // Flush with a byte in flight
        model_on = 1'b1; rise_delay = 1; busy_len = 8;
        wr(8'h11);
        wr(8'h22);
        s = last_start_cyc;
        wr(8'h33);
        while (cycle < s + 3) cyc();
        chk("flush_pre_count", 32'(count), 32'(2));
        flush        = 1'b1;
        bus.wr_data  = 8'h44;
        bus.wr_valid = 1'b1;
        #1;
        chk("flush_wr_ready", 32'(bus.wr_ready), 32'(0));
        cyc();
        flush        = 1'b0;
        bus.wr_valid = 1'b0;
        exp_q.delete();
        chk("flush_count", 32'(count), 32'(0));
        n0 = starts;
        repeat (25) cyc();
        chk("flush_no_start", 32'(starts - n0), 32'(0));
        chk("flush_inflight_data", 32'(tx_data), 32'(8'h11));
        chk("flush_count_end", 32'(count), 32'(0));

        // Reset mid-frame with bytes queued
        for (int i = 0; i < 4; i++) wr(8'hA1 + 8'(i));
        chk("rstmid_queued", 32'(count), 32'(3));
        reset = 1'b1;
        cyc();
        chk("rstmid_count", 32'(count), 32'(0));
        chk("rstmid_tx_data", 32'(tx_data), 32'(0));
        chk("rstmid_tx_start", 32'(tx_start), 32'(0));
        chk("rstmid_wr_ready", 32'(bus.wr_ready), 32'(0));
        cyc();
        reset = 1'b0;
        exp_q.delete();
        n0 = starts;
        repeat (20) cyc();
        chk("rstmid_no_start", 32'(starts - n0), 32'(0));
        wr(8'h5A);
        cyc();
        chk("rstmid_new_start", 32'(last_start_cyc), 32'(last_wr_cyc + 2));
        drain(500);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
